// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and defaults for the parking gate scheduler: FSM states, latched request and lot limits.
package parking_gate_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic exit;
    logic uni;
  } gate_req_t;

  localparam int TOTAL_CAP_DEF   = 700;
  localparam int OPEN_CYCLES_DEF = 16;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Gate-side request/response bus and occupancy outputs of the scheduler.
// PARKING_SCHED_STATS_EN adds the rejection counters to the bus.
interface parking_gate_scheduler_if #(
  parameter int N_GATES = 4,
  parameter int CNT_W   = 10
);

  logic [N_GATES-1:0] req_valid;
  logic [N_GATES-1:0] req_exit;
  logic [N_GATES-1:0] req_uni;
  logic [CNT_W-1:0]   uni_cap;
  logic [CNT_W-1:0]   gen_cap;
  logic [N_GATES-1:0] resp_valid;
  logic [N_GATES-1:0] resp_ok;
  logic [N_GATES-1:0] gate_open;
  logic [CNT_W-1:0]   uni_parked;
  logic [CNT_W-1:0]   gen_parked;
  logic [CNT_W-1:0]   uni_free;
  logic [CNT_W-1:0]   gen_free;
  logic               lot_full;
`ifdef PARKING_SCHED_STATS_EN
  logic [15:0]        rej_entry_cnt;
  logic [15:0]        rej_exit_cnt;

  modport master (
    output req_valid, req_exit, req_uni, uni_cap, gen_cap,
    input  resp_valid, resp_ok, gate_open, uni_parked, gen_parked,
    input  uni_free, gen_free, lot_full, rej_entry_cnt, rej_exit_cnt
  );
  modport slave (
    input  req_valid, req_exit, req_uni, uni_cap, gen_cap,
    output resp_valid, resp_ok, gate_open, uni_parked, gen_parked,
    output uni_free, gen_free, lot_full, rej_entry_cnt, rej_exit_cnt
  );
`else
  modport master (
    output req_valid, req_exit, req_uni, uni_cap, gen_cap,
    input  resp_valid, resp_ok, gate_open, uni_parked, gen_parked,
    input  uni_free, gen_free, lot_full
  );
  modport slave (
    input  req_valid, req_exit, req_uni, uni_cap, gen_cap,
    output resp_valid, resp_ok, gate_open, uni_parked, gen_parked,
    output uni_free, gen_free, lot_full
  );
`endif

endinterface

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any_eligible
);

  always_comb begin
    o_grant        = '0;
    o_any_eligible = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any_eligible && i_eligible[(int'(i_ptr) + k) % N]) begin
        o_any_eligible = 1'b1;
        o_grant        = IDX_W'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Round-robin gate scheduler sharing one occupancy datapath; IDLE->EVAL->RESP, response 3 cycles after request.
// PARKING_SCHED_STATS_EN adds saturating rejected-entry/exit counters.
module parking_gate_scheduler
  import parking_gate_scheduler_pkg::*;
#(
  parameter int N_GATES     = 4,
  parameter int CNT_W       = 10,
  parameter int TOTAL_CAP   = TOTAL_CAP_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  parking_gate_scheduler_if.slave  s_if
);

  localparam int IDX_W   = (N_GATES > 1) ? $clog2(N_GATES) : 1;
  localparam int TMR_W   = $clog2(OPEN_CYCLES + 1);
  localparam int TOTAL_W = CNT_W + 1;

  sched_state_t       r_state;
  gate_req_t          r_req;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_ok;
  logic [N_GATES-1:0] r_resp_valid;
  logic [N_GATES-1:0] r_resp_ok;
  logic [CNT_W-1:0]   r_uni_parked;
  logic [CNT_W-1:0]   r_gen_parked;
  logic [CNT_W-1:0]   r_uni_free;
  logic [CNT_W-1:0]   r_gen_free;
  logic [TMR_W-1:0]   r_timer [N_GATES];

  logic [N_GATES-1:0] w_gate_open;
  logic [N_GATES-1:0] w_eligible;
  logic [IDX_W-1:0]   w_grant;
  logic               w_any;
  logic [TOTAL_W-1:0] w_total;
  logic [CNT_W-1:0]   w_cls_parked;
  logic [CNT_W-1:0]   w_cls_cap;
  logic               w_ok;

  always_comb begin
    for (int i = 0; i < N_GATES; i++) begin
      w_gate_open[i] = (r_timer[i] != '0);
    end
  end

  // The gate just answered is masked for one cycle so it can drop req_valid.
  assign w_eligible = s_if.req_valid & ~w_gate_open & ~r_resp_valid;

  rr_arbiter #(.N(N_GATES), .IDX_W(IDX_W)) u_arb (
    .i_eligible     (w_eligible),
    .i_ptr          (r_ptr),
    .o_grant        (w_grant),
    .o_any_eligible (w_any)
  );

  assign w_total      = {1'b0, r_uni_parked} + {1'b0, r_gen_parked};
  assign w_cls_parked = r_req.uni ? r_uni_parked : r_gen_parked;
  assign w_cls_cap    = r_req.uni ? s_if.uni_cap : s_if.gen_cap;
  assign w_ok = r_req.exit ? (w_cls_parked != '0)
                           : ((w_cls_parked < w_cls_cap) && (w_total < TOTAL_W'(TOTAL_CAP))
                              && (w_cls_parked != '1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_gnt        <= '0;
      r_ptr        <= '0;
      r_ok         <= 1'b0;
      r_resp_valid <= '0;
      r_resp_ok    <= '0;
      r_uni_parked <= '0;
      r_gen_parked <= '0;
    end else begin
      r_resp_valid <= '0;
      r_resp_ok    <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt      <= w_grant;
            r_req.exit <= s_if.req_exit[w_grant];
            r_req.uni  <= s_if.req_uni[w_grant];
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          r_ok <= w_ok;
          if (w_ok) begin
            if (r_req.uni) r_uni_parked <= r_req.exit ? r_uni_parked - 1'b1 : r_uni_parked + 1'b1;
            else           r_gen_parked <= r_req.exit ? r_gen_parked - 1'b1 : r_gen_parked + 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_resp_valid[r_gnt] <= 1'b1;
          r_resp_ok[r_gnt]    <= r_ok;
          r_ptr   <= (r_gnt == IDX_W'(N_GATES - 1)) ? '0 : r_gnt + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_GATES; i++) r_timer[i] <= '0;
    end else begin
      for (int i = 0; i < N_GATES; i++) begin
        if (r_state == RESP && r_ok && r_gnt == IDX_W'(i)) r_timer[i] <= TMR_W'(OPEN_CYCLES);
        else if (r_timer[i] != '0)                          r_timer[i] <= r_timer[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_uni_free <= '0;
      r_gen_free <= '0;
    end else begin
      r_uni_free <= (s_if.uni_cap > r_uni_parked) ? s_if.uni_cap - r_uni_parked : '0;
      r_gen_free <= (s_if.gen_cap > r_gen_parked) ? s_if.gen_cap - r_gen_parked : '0;
    end
  end

`ifdef PARKING_SCHED_STATS_EN
  logic [15:0] r_rej_entry_cnt;
  logic [15:0] r_rej_exit_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rej_entry_cnt <= '0;
      r_rej_exit_cnt  <= '0;
    end else if (r_state == RESP && !r_ok) begin
      if (r_req.exit && r_rej_exit_cnt != 16'hFFFF)        r_rej_exit_cnt  <= r_rej_exit_cnt + 1'b1;
      else if (!r_req.exit && r_rej_entry_cnt != 16'hFFFF) r_rej_entry_cnt <= r_rej_entry_cnt + 1'b1;
    end
  end

  assign s_if.rej_entry_cnt = r_rej_entry_cnt;
  assign s_if.rej_exit_cnt  = r_rej_exit_cnt;
`endif

  assign s_if.resp_valid = r_resp_valid;
  assign s_if.resp_ok    = r_resp_ok;
  assign s_if.gate_open  = w_gate_open;
  assign s_if.uni_parked = r_uni_parked;
  assign s_if.gen_parked = r_gen_parked;
  assign s_if.uni_free   = r_uni_free;
  assign s_if.gen_free   = r_gen_free;
  assign s_if.lot_full   = (w_total >= TOTAL_W'(TOTAL_CAP));

endmodule
